// File: rtl/id_exe_fwd_reg_pkg.sv
// id_exe_fwd_reg_pkg: shared widths and forwarding-select encodings for the ID/EXE register
package id_exe_fwd_reg_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CMD_W  = 4;
    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_REG    = 2'b00;
    localparam fwd_sel_t FWD_WB     = 2'b01;
    localparam fwd_sel_t FWD_EXEMEM = 2'b10;
endpackage

// File: rtl/id_exe_fwd_reg_if.sv
// id_exe_fwd_reg_if: ID-side inputs, EXE/MEM feedback and EXE-side outputs of the ID/EXE register
interface id_exe_fwd_reg_if #(
    parameter int DATA_W = id_exe_fwd_reg_pkg::DATA_W,
    parameter int REG_W  = id_exe_fwd_reg_pkg::REG_W,
    parameter int CMD_W  = id_exe_fwd_reg_pkg::CMD_W
);
    logic              freeze, flush;
    logic              id_valid, id_use_src2, id_wb_en, id_mem_read, id_mem_write;
    logic [DATA_W-1:0] id_op1, id_op2src;
    logic [REG_W-1:0]  id_src1, id_src2, id_dest;
    logic [CMD_W-1:0]  id_exe_cmd;
    logic [REG_W-1:0]  exe_dest, mem_dest;
    logic              exe_wb_en, exe_mem_read, mem_wb_en;
    logic              hazard_stall;
    logic              ex_valid, ex_wb_en, ex_mem_read, ex_mem_write;
    logic [DATA_W-1:0] ex_op1, ex_op2src;
    logic [REG_W-1:0]  ex_dest;
    logic [CMD_W-1:0]  ex_exe_cmd;
    logic [1:0]        forwardOp1, forwardOp2;
    modport master (
        output freeze, flush, id_valid, id_use_src2, id_wb_en, id_mem_read, id_mem_write,
               id_op1, id_op2src, id_src1, id_src2, id_dest, id_exe_cmd,
               exe_dest, mem_dest, exe_wb_en, exe_mem_read, mem_wb_en,
        input  hazard_stall, ex_valid, ex_wb_en, ex_mem_read, ex_mem_write,
               ex_op1, ex_op2src, ex_dest, ex_exe_cmd, forwardOp1, forwardOp2
    );
    modport slave (
        input  freeze, flush, id_valid, id_use_src2, id_wb_en, id_mem_read, id_mem_write,
               id_op1, id_op2src, id_src1, id_src2, id_dest, id_exe_cmd,
               exe_dest, mem_dest, exe_wb_en, exe_mem_read, mem_wb_en,
        output hazard_stall, ex_valid, ex_wb_en, ex_mem_read, ex_mem_write,
               ex_op1, ex_op2src, ex_dest, ex_exe_cmd, forwardOp1, forwardOp2
    );
endinterface

// File: rtl/id_exe_fwd_reg_fwd_sel_calc.sv
// fwd_sel_calc: forwarding select for one source register; the younger EXE producer wins over MEM
module fwd_sel_calc
    import id_exe_fwd_reg_pkg::*;
#(
    parameter int REG_W = id_exe_fwd_reg_pkg::REG_W
) (
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output fwd_sel_t         sel
);
    assign sel = (!use_src || src == '0)         ? FWD_REG    :
                 (exe_wb_en && exe_dest == src) ? FWD_EXEMEM :
                 (mem_wb_en && mem_dest == src) ? FWD_WB     : FWD_REG;
endmodule

// File: rtl/id_exe_fwd_reg.sv
// id_exe_fwd_reg: ID/EXE pipeline register with load-use stall and pre-registered forwarding selects
module id_exe_fwd_reg
    import id_exe_fwd_reg_pkg::*;
#(
    parameter int DATA_W = id_exe_fwd_reg_pkg::DATA_W,
    parameter int REG_W  = id_exe_fwd_reg_pkg::REG_W,
    parameter int CMD_W  = id_exe_fwd_reg_pkg::CMD_W
) (
    input logic          clk,
    input logic          rst_n,
    id_exe_fwd_reg_if.slave bus
);
    logic              hazard, bubble;
    fwd_sel_t          sel1, sel2;
    logic              valid_q, valid_d, wb_en_q, wb_en_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2src_q, op2src_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic [CMD_W-1:0]  exe_cmd_q, exe_cmd_d;
    fwd_sel_t          fwd1_q, fwd1_d, fwd2_q, fwd2_d;
    fwd_sel_calc #(.REG_W(REG_W)) u_sel1 (
        .src(bus.id_src1), .use_src(1'b1),
        .exe_dest(bus.exe_dest), .exe_wb_en(bus.exe_wb_en),
        .mem_dest(bus.mem_dest), .mem_wb_en(bus.mem_wb_en), .sel(sel1)
    );
    fwd_sel_calc #(.REG_W(REG_W)) u_sel2 (
        .src(bus.id_src2), .use_src(bus.id_use_src2),
        .exe_dest(bus.exe_dest), .exe_wb_en(bus.exe_wb_en),
        .mem_dest(bus.mem_dest), .mem_wb_en(bus.mem_wb_en), .sel(sel2)
    );
    // a load in EXE cannot forward yet, so a dependent instruction becomes a bubble and retries
    assign hazard = !bus.flush && bus.id_valid && bus.exe_mem_read && bus.exe_wb_en && bus.exe_dest != '0 &&
                    (bus.exe_dest == bus.id_src1 || (bus.id_use_src2 && bus.exe_dest == bus.id_src2));
    assign bubble = bus.flush || hazard || !bus.id_valid;
    always_comb begin
        valid_d     = bus.freeze ? valid_q     : !bubble;
        wb_en_d     = bus.freeze ? wb_en_q     : !bubble && bus.id_wb_en;
        mem_read_d  = bus.freeze ? mem_read_q  : !bubble && bus.id_mem_read;
        mem_write_d = bus.freeze ? mem_write_q : !bubble && bus.id_mem_write;
        op1_d       = bus.freeze ? op1_q       : bubble ? '0 : bus.id_op1;
        op2src_d    = bus.freeze ? op2src_q    : bubble ? '0 : bus.id_op2src;
        dest_d      = bus.freeze ? dest_q      : bubble ? '0 : bus.id_dest;
        exe_cmd_d   = bus.freeze ? exe_cmd_q   : bubble ? '0 : bus.id_exe_cmd;
        fwd1_d      = bus.freeze ? fwd1_q      : bubble ? FWD_REG : sel1;
        fwd2_d      = bus.freeze ? fwd2_q      : bubble ? FWD_REG : sel2;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            wb_en_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            op1_q       <= '0;
            op2src_q    <= '0;
            dest_q      <= '0;
            exe_cmd_q   <= '0;
            fwd1_q      <= FWD_REG;
            fwd2_q      <= FWD_REG;
        end else begin
            valid_q     <= valid_d;
            wb_en_q     <= wb_en_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            op1_q       <= op1_d;
            op2src_q    <= op2src_d;
            dest_q      <= dest_d;
            exe_cmd_q   <= exe_cmd_d;
            fwd1_q      <= fwd1_d;
            fwd2_q      <= fwd2_d;
        end
    end
    assign bus.hazard_stall = hazard;
    assign bus.ex_valid     = valid_q;
    assign bus.ex_wb_en     = wb_en_q;
    assign bus.ex_mem_read  = mem_read_q;
    assign bus.ex_mem_write = mem_write_q;
    assign bus.ex_op1       = op1_q;
    assign bus.ex_op2src    = op2src_q;
    assign bus.ex_dest      = dest_q;
    assign bus.ex_exe_cmd   = exe_cmd_q;
    assign bus.forwardOp1   = fwd1_q;
    assign bus.forwardOp2   = fwd2_q;
endmodule
